bus_transfer_controller: RTL and testbench

//  Initiator side of the dual-bus (BUSA/BUSB) register-transfer interface.
//  - Accepts one transfer command at a time over a valid/ready handshake.
//  - Sequences per-register enable/latch/inc strobes and bus selects so that each bus has exactly one driver.
//  - Holds data stable across every latch pulse on the level-latched register file.
//  - Sits between the instruction decoder and the bank of 8-bit bus registers.

---
 rtl/bus_transfer_controller.sv | 190 +++++++++++++++++++
 tb/tb_bus_transfer_controller.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller
//   Initiator for the dual-bus (BUSA/BUSB) register-transfer interface.
//   Takes one MOVE/INC command at a time and sequences the per-register
//   enable/latch/inc strobes and bus selects so each bus has one driver.
//   Optional feature macro: BUS_IMM_EN (immediate source driven by this block).
module bus_transfer_controller #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [IDX_W-1:0]    cmd_src,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic                cmd_bus,
  input  logic                cmd_imm_en,
  input  logic [DATA_W-1:0]   cmd_imm,
  output logic [NUM_REGS-1:0] enable,
  output logic [NUM_REGS-1:0] latch,
  output logic [NUM_REGS-1:0] inc,
  output logic [NUM_REGS-1:0] out_bus_sel,
  output logic [NUM_REGS-1:0] in_bus_sel,
  inout  wire  [DATA_W-1:0]   BUSA,
  inout  wire  [DATA_W-1:0]   BUSB,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic OP_MOVE = 1'b0;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, DRIVE, LATCH, INCR, RELEASE} state_t;

  state_t state_q, state_d;

  // captured command; inputs are don't-care once accepted
  logic             op_q, bus_q;
  logic [IDX_W-1:0] src_q, dst_q;

  logic                accept;
  logic                c_op, c_bus, c_imm_en;
  logic [IDX_W-1:0]    c_src, c_dst;
  logic                src_bad, dst_bad, same_reg, reject;

  logic [NUM_REGS-1:0] enable_d, latch_d, inc_d, out_bus_sel_d, in_bus_sel_d;
  logic                done_d, err_d;

  assign accept = cmd_valid & cmd_ready;

  // Output registers are loaded from the *next* state, so at the accept edge
  // the live inputs must feed the decode; afterwards the captured copy does.
  assign c_op  = (state_q == IDLE) ? cmd_op  : op_q;
  assign c_bus = (state_q == IDLE) ? cmd_bus : bus_q;
  assign c_src = (state_q == IDLE) ? cmd_src : src_q;
  assign c_dst = (state_q == IDLE) ? cmd_dst : dst_q;

`ifdef BUS_IMM_EN
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;
  logic              drv_a_q, drv_b_q, drv_a_d, drv_b_d;

  assign c_imm_en = (state_q == IDLE) ? cmd_imm_en : imm_en_q;

  assign BUSA = drv_a_q ? imm_q : {DATA_W{1'bz}};
  assign BUSB = drv_b_q ? imm_q : {DATA_W{1'bz}};

  // immediate capture and registered bus drive enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      drv_a_q  <= 1'b0;
      drv_b_q  <= 1'b0;
    end else begin
      drv_a_q <= drv_a_d;
      drv_b_q <= drv_b_d;
      if (accept) begin
        imm_en_q <= cmd_imm_en;
        imm_q    <= cmd_imm;
      end
    end
  end
`else
  logic unused_imm;
  assign unused_imm = ^{cmd_imm_en, cmd_imm};
  assign c_imm_en   = 1'b0;
  assign BUSA       = {DATA_W{1'bz}};
  assign BUSB       = {DATA_W{1'bz}};
`endif

  // Rejections: src is only checked when a source register is actually used.
  assign src_bad  = ({1'b0, c_src} >= NUM_REGS_L);
  assign dst_bad  = ({1'b0, c_dst} >= NUM_REGS_L);
  assign same_reg = (c_src == c_dst);
  assign reject   = dst_bad | ((c_op == OP_MOVE) & ~c_imm_en & (src_bad | same_reg));

  // next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    enable_d      = '0;
    latch_d       = '0;
    inc_d         = '0;
    out_bus_sel_d = '0;
    in_bus_sel_d  = '0;
    done_d        = 1'b0;
    err_d         = 1'b0;
`ifdef BUS_IMM_EN
    drv_a_d       = 1'b0;
    drv_b_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject)                 err_d   = 1'b1;
          else if (c_op == OP_MOVE)   state_d = DRIVE;
          else                        state_d = INCR;
        end
      end
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = RELEASE;
      INCR:    state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      DRIVE, LATCH: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          enable_d[i]      = ~c_imm_en & (c_src == IDX_W'(i));
          out_bus_sel_d[i] = ~c_imm_en & (c_src == IDX_W'(i)) & c_bus;
          in_bus_sel_d[i]  = (c_dst == IDX_W'(i)) & c_bus;
          latch_d[i]       = (state_d == LATCH) & (c_dst == IDX_W'(i));
        end
`ifdef BUS_IMM_EN
        drv_a_d = c_imm_en & ~c_bus;
        drv_b_d = c_imm_en &  c_bus;
`endif
      end
      INCR: begin
        for (int i = 0; i < NUM_REGS; i++)
          inc_d[i] = (c_dst == IDX_W'(i));
      end
      RELEASE: done_d = 1'b1;
      default: ;
    endcase
  end

  // state, registered outputs and command capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      enable      <= '0;
      latch       <= '0;
      inc         <= '0;
      out_bus_sel <= '0;
      in_bus_sel  <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      op_q        <= 1'b0;
      bus_q       <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
    end else begin
      state_q     <= state_d;
      enable      <= enable_d;
      latch       <= latch_d;
      inc         <= inc_d;
      out_bus_sel <= out_bus_sel_d;
      in_bus_sel  <= in_bus_sel_d;
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      done        <= done_d;
      err         <= err_d;
      if (accept) begin
        op_q  <= cmd_op;
        bus_q <= cmd_bus;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: models the 8-register level-latched file,
// keeps expected register contents, and checks strobes, timing and results.
module tb_bus_transfer_controller;

  localparam int NR = 8;
  localparam int IW = 4;   // wide enough to express out-of-range indices
  localparam int DW = 8;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_op, cmd_bus, cmd_imm_en;
  logic [IW-1:0] cmd_src, cmd_dst;
  logic [DW-1:0] cmd_imm;
  logic [NR-1:0] enable, latch, inc, out_bus_sel, in_bus_sel;
  logic          busy, done, err;
  wire  [DW-1:0] busa, busb;

  bus_transfer_controller #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_bus(cmd_bus),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .enable(enable), .latch(latch), .inc(inc),
    .out_bus_sel(out_bus_sel), .in_bus_sel(in_bus_sel),
    .BUSA(busa), .BUSB(busb),
    .busy(busy), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int idx; logic [DW-1:0] val; } sb_t;
  sb_t sb[$];

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] exp_regs [NR];
  logic [DW-1:0] va, vb;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 7) ? 8'hFF : 8'(8'h11 * (i + 1));
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // value present on each bus as seen by the register file
  always_comb begin
    va = '0;
    vb = '0;
    for (int i = 0; i < NR; i++)
      if (enable[i]) begin
        if (out_bus_sel[i]) vb = regs[i];
        else                va = regs[i];
      end
`ifdef BUS_IMM_EN
    if (enable == '0) begin
      va = busa;
      vb = busb;
    end
`endif
  end

  // level-latched register file model, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (reset)              regs[i] <= init_val(i);
      else if (latch[i])      regs[i] <= in_bus_sel[i] ? vb : va;
      else if (inc[i])        regs[i] <= regs[i] + 8'd1;
    end
  end

  // single-driver / single-strobe invariants every cycle
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ($countones(enable) > 1 || $countones(latch | inc) > 1) begin
        errors++;
        $display("FAIL onehot: enable=%b latch=%b inc=%b want at most one bit each", enable, latch, inc);
      end
      checks++;
      if ((out_bus_sel & ~enable) != '0) begin
        errors++;
        $display("FAIL stray_out_sel: out_bus_sel=%b enable=%b want no sel without enable", out_bus_sel, enable);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_exp();
    for (int i = 0; i < NR; i++) exp_regs[i] = init_val(i);
    sb.delete();
  endtask

  // wait for cmd_ready, present the command for one accepting edge
  task automatic issue(input logic op, input int src, input int dst, input logic bus,
                       input logic imm_en, input logic [DW-1:0] imm);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("FAIL ready_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_src = IW'(src); cmd_dst = IW'(dst);
    cmd_bus = bus; cmd_imm_en = imm_en; cmd_imm = imm;
    tick();
    cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0; cmd_imm_en = 1'b0;
  endtask

  task automatic push_move(input int src, input int dst);
    sb_t e;
    exp_regs[dst] = exp_regs[src];
    e.idx = dst; e.val = exp_regs[dst];
    sb.push_back(e);
  endtask

  task automatic push_inc(input int dst);
    sb_t e;
    exp_regs[dst] = exp_regs[dst] + 8'd1;
    e.idx = dst; e.val = exp_regs[dst];
    sb.push_back(e);
  endtask

  // called one cycle after acceptance; checks done latency and pops result
  task automatic wait_done(input int exp_lat, input string name);
    int n;
    sb_t e;
    n = 1;
    while (!done && n < 12) begin tick(); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles want 1", name, done, n);
    end else if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, n, exp_lat);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (regs[e.idx] !== e.val) begin
        errors++;
        $display("FAIL %s_result: reg%0d=%h want %h", name, e.idx, regs[e.idx], e.val);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_bus = 1'b0; cmd_imm_en = 1'b0; cmd_imm = '0;
    init_exp();
    repeat (2) tick();
    checks++;
    if ({enable, latch, inc, out_bus_sel, in_bus_sel} !== '0 || {cmd_ready, busy, done, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b la=%b in=%b osel=%b isel=%b rdy/busy/done/err=%b want all 0",
               enable, latch, inc, out_bus_sel, in_bus_sel, {cmd_ready, busy, done, err});
    end
    #3 reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_move();
    issue(1'b0, 2, 5, 1'b1, 1'b0, '0);
    push_move(2, 5);
    checks++;
    if (enable !== 8'h04 || out_bus_sel !== 8'h04 || in_bus_sel !== 8'h20 || latch !== 8'h00
        || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL move_drive: en=%b osel=%b isel=%b la=%b busy=%b rdy=%b want 04 04 20 00 1 0",
               enable, out_bus_sel, in_bus_sel, latch, busy, cmd_ready);
    end
    tick();
    checks++;
    if (enable !== 8'h04 || out_bus_sel !== 8'h04 || latch !== 8'h20 || done !== 1'b0) begin
      errors++;
      $display("FAIL move_latch: en=%b osel=%b la=%b done=%b want 04 04 20 0", enable, out_bus_sel, latch, done);
    end
    tick();
    checks++;
    if (enable !== 8'h00 || latch !== 8'h00 || in_bus_sel !== 8'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL move_release: en=%b la=%b isel=%b done=%b want 00 00 00 1", enable, latch, in_bus_sel, done);
    end
    wait_done(1, "move");
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL move_idle: done=%b rdy=%b busy=%b want 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_inc_wrap();
    issue(1'b1, 0, 7, 1'b0, 1'b0, '0);
    push_inc(7);
    checks++;
    if (inc !== 8'h80 || enable !== 8'h00 || latch !== 8'h00) begin
      errors++;
      $display("FAIL inc_strobe: inc=%b en=%b la=%b want 80 00 00", inc, enable, latch);
    end
    wait_done(2, "inc");
    checks++;
    if (regs[7] !== 8'h00 || inc !== 8'h00) begin
      errors++;
      $display("FAIL inc_wrap: reg7=%h inc=%b want 00 00", regs[7], inc);
    end
  endtask

  task automatic test_reject();
    int bad [3][3];
    bad = '{'{3, 3, 0}, '{1, 9, 0}, '{9, 2, 0}};
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, bad[k][0], bad[k][1], 1'b0, 1'b0, '0);
      checks++;
      if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || (enable | latch | inc) !== 8'h00) begin
        errors++;
        $display("FAIL reject_%0d: err=%b rdy=%b busy=%b strobes=%b want 1 1 0 00",
                 k, err, cmd_ready, busy, enable | latch | inc);
      end
      tick();
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse_%0d: err=%b done=%b want 0 0", k, err, done);
      end
    end
    issue(1'b1, 0, 8, 1'b0, 1'b0, '0);
    checks++;
    if (err !== 1'b1 || inc !== 8'h00) begin
      errors++;
      $display("FAIL reject_inc: err=%b inc=%b want 1 00", err, inc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src = 4'd1; cmd_dst = 4'd4; cmd_bus = 1'b0;
    push_move(1, 4);
    tick();
    cmd_op = 1'b1; cmd_dst = 4'd0; cmd_src = 4'd6;
    checks++;
    if (cmd_ready !== 1'b0 || enable !== 8'h02) begin
      errors++;
      $display("FAIL b2b_drive: rdy=%b en=%b want 0 02", cmd_ready, enable);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || latch !== 8'h10) begin
      errors++;
      $display("FAIL b2b_latch: rdy=%b la=%b want 0 10", cmd_ready, latch);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: rdy=%b done=%b want 0 1", cmd_ready, done);
    end
    wait_done(1, "b2b_move");
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || inc !== 8'h00) begin
      errors++;
      $display("FAIL b2b_idle: rdy=%b inc=%b want 1 00", cmd_ready, inc);
    end
    push_inc(0);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (inc !== 8'h01 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: inc=%b rdy=%b want 01 0", inc, cmd_ready);
    end
    wait_done(2, "b2b_inc");
    tick();
  endtask

`ifdef BUS_IMM_EN
  task automatic test_imm();
    issue(1'b0, 1, 1, 1'b0, 1'b1, 8'hA5);
    exp_regs[1] = 8'hA5;
    sb.push_back('{idx: 1, val: 8'hA5});
    checks++;
    if (busa !== 8'hA5 || enable !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL imm_drive: busa=%h en=%b err=%b want A5 00 0", busa, enable, err);
    end
    tick();
    checks++;
    if (busa !== 8'hA5 || latch !== 8'h02) begin
      errors++;
      $display("FAIL imm_latch: busa=%h la=%b want A5 02", busa, latch);
    end
    tick();
    checks++;
    if (busa === 8'hA5) begin
      errors++;
      $display("FAIL imm_release: busa=%h want released", busa);
    end
    wait_done(1, "imm");
    tick();
  endtask
`endif

  task automatic test_random();
    int op, src, dst, bus;
    logic rej;
    for (int k = 0; k < 24; k++) begin
      op  = int'($urandom_range(0, 1));
      src = int'($urandom_range(0, 9));
      dst = int'($urandom_range(0, 9));
      bus = int'($urandom_range(0, 1));
      rej = (dst >= NR) || (op == 0 && (src >= NR || src == dst));
      issue(1'(op), src, dst, 1'(bus), 1'b0, '0);
      if (rej) begin
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_reject_%0d: err=%b busy=%b want 1 0", k, err, busy);
        end
        tick();
      end else begin
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rand_accept_%0d: err=%b busy=%b want 0 1", k, err, busy);
        end
        if (op == 0) begin
          push_move(src, dst);
          wait_done(3, "rand_move");
        end else begin
          push_inc(dst);
          wait_done(2, "rand_inc");
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_midxfer();
    int seen;
    issue(1'b0, 0, 6, 1'b1, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ((enable | latch | inc | out_bus_sel | in_bus_sel) !== 8'h00 || {busy, done, err, cmd_ready} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_async: strobes=%b busy/done/err/rdy=%b want 00 0000",
               enable | latch | inc | out_bus_sel | in_bus_sel, {busy, done, err, cmd_ready});
    end
    init_exp();
    tick();
    #3 reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_lost: done_pulses=%0d rdy=%b want 0 1", seen, cmd_ready);
    end
    issue(1'b0, 3, 6, 1'b0, 1'b0, '0);
    push_move(3, 6);
    wait_done(3, "post_reset_move");
    tick();
  endtask

  initial begin
    test_reset();
    test_move();
    test_inc_wrap();
    test_reject();
    test_back_to_back();
`ifdef BUS_IMM_EN
    test_imm();
`endif
    test_random();
    test_reset_midxfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
